// File: rtl/mac_ifmaps_multirow_fifo_pkg.sv
// Shared sizing helpers for the MAC-array input FIFOs.
// Both the ifmaps FIFO and the weights FIFO use these helpers.
package mac_ifmaps_multirow_fifo_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Pointers need at least one bit even when the depth would need none.
    function automatic int ptr_width(input int depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

endpackage

// File: rtl/mac_fifo_ctrl.sv
// Pointer, occupancy, status and sticky-error bookkeeping for a single-clock FIFO.
// The weights FIFO reuses it; storage and read data live in the instantiating module.
module mac_fifo_ctrl
    import mac_ifmaps_multirow_fifo_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int AFULL_LEVEL = DEPTH - 1,
    localparam int PW         = ptr_width(DEPTH),
    localparam int CW         = clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          fifo_read,
    input  logic          flush,
    output logic          write_en,
    output logic          read_en,
    output logic [PW-1:0] wr_ptr,
    output logic [PW-1:0] rd_ptr,
    output logic [CW-1:0] fifo_count,
    output logic          fifo_full,
    output logic          fifo_empty,
    output logic          almost_full,
    output logic          overflow_err,
    output logic          underflow_err
);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          write_en_s, read_en_s;
    logic          empty_s, full_s;

    assign empty_s = (count_q == CW'(0));
    assign full_s  = (count_q == CW'(DEPTH));

    // Accept/pop qualification; a pop frees the slot a same-cycle write needs.
    always_comb begin
        write_en_s = 1'b0;
        read_en_s  = 1'b0;
        if (flush) begin
            write_en_s = 1'b0;
            read_en_s  = 1'b0;
        end else begin
            read_en_s  = fifo_read & ~empty_s;
            write_en_s = in_valid & (~full_s | read_en_s);
        end
    end

    // Next-state for pointers, count and error flags; flush overrides all.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (flush) begin
            wr_ptr_d = PW'(0);
            rd_ptr_d = PW'(0);
            count_d  = CW'(0);
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (write_en_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (read_en_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({write_en_s, read_en_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            ovf_d = ovf_q | (in_valid & ~write_en_s);
            unf_d = unf_q | (fifo_read & empty_s);
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= PW'(0);
            rd_ptr_q <= PW'(0);
            count_q  <= CW'(0);
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign write_en      = write_en_s;
    assign read_en       = read_en_s;
    assign wr_ptr        = wr_ptr_q;
    assign rd_ptr        = rd_ptr_q;
    assign fifo_count    = count_q;
    assign fifo_full     = full_s;
    assign fifo_empty    = empty_s;
    assign almost_full   = (count_q >= CW'(AFULL_LEVEL));
    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;

endmodule

// File: rtl/mac_ifmaps_multirow_fifo.sv
// Multi-row ifmaps FIFO feeding the MAC array rows: NUM_ROWS lanes share one pointer set.
// Read data is either registered (1-cycle latency) or first-word-fall-through.
module mac_ifmaps_multirow_fifo
    import mac_ifmaps_multirow_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_ROWS    = 5,
    parameter int DEPTH       = 4,
    parameter int AFULL_LEVEL = DEPTH - 1,
    parameter int FWFT        = 0,
    localparam int W          = NUM_ROWS * DATA_WIDTH,
    localparam int PW         = ptr_width(DEPTH),
    localparam int CW         = clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    input  logic          fifo_read,
    input  logic          flush,
    output logic [W-1:0]  out_data,
    output logic          out_valid,
    output logic          fifo_full,
    output logic          fifo_empty,
    output logic          almost_full,
    output logic [CW-1:0] fifo_count,
    output logic          overflow_err,
    output logic          underflow_err
);

    logic          write_en_s, read_en_s, empty_s;
    logic [PW-1:0] wr_ptr_s, rd_ptr_s;
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];

    mac_fifo_ctrl #(
        .DEPTH       (DEPTH),
        .AFULL_LEVEL (AFULL_LEVEL)
    ) u_ctrl (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .fifo_read     (fifo_read),
        .flush         (flush),
        .write_en      (write_en_s),
        .read_en       (read_en_s),
        .wr_ptr        (wr_ptr_s),
        .rd_ptr        (rd_ptr_s),
        .fifo_count    (fifo_count),
        .fifo_full     (fifo_full),
        .fifo_empty    (empty_s),
        .almost_full   (almost_full),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    assign fifo_empty = empty_s;

    // Storage write: only the slot at the write pointer changes.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (write_en_s) begin
            mem_d[wr_ptr_s] = in_data;
        end else begin
            mem_d[wr_ptr_s] = mem_q[wr_ptr_s];
        end
    end

    // Storage registers; reset clears so a fall-through head reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {W{1'b0}};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign out_data  = mem_q[rd_ptr_s];
        assign out_valid = ~empty_s;
    end else begin : g_reg
        logic [W-1:0] out_data_q, out_data_d;
        logic         out_valid_q, out_valid_d;

        // Popped word capture; out_valid pulses one cycle per pop and data holds otherwise.
        always_comb begin
            out_data_d  = out_data_q;
            out_valid_d = 1'b0;
            if (read_en_s) begin
                out_data_d  = mem_q[rd_ptr_s];
                out_valid_d = 1'b1;
            end else begin
                out_data_d  = out_data_q;
                out_valid_d = 1'b0;
            end
        end

        // Output register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_data_q  <= {W{1'b0}};
                out_valid_q <= 1'b0;
            end else begin
                out_data_q  <= out_data_d;
                out_valid_q <= out_valid_d;
            end
        end

        assign out_data  = out_data_q;
        assign out_valid = out_valid_q;
    end

endmodule

// File: tb/tb_mac_ifmaps_multirow_fifo.sv
// Directed bench: three instances (DEPTH=4 registered, DEPTH=4 fall-through, DEPTH=2 registered)
// share one stimulus stream; each scenario checks the instance it targets.
module tb_mac_ifmaps_multirow_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [39:0] in_data = 40'h0;
    logic        fifo_read = 1'b0;
    logic        flush = 1'b0;

    logic [39:0] a_data, f_data, w_data;
    logic        a_valid, f_valid, w_valid;
    logic        a_full, f_full, w_full;
    logic        a_empty, f_empty, w_empty;
    logic        a_afull, f_afull, w_afull;
    logic [2:0]  a_count, f_count;
    logic [1:0]  w_count;
    logic        a_ovf, f_ovf, w_ovf;
    logic        a_unf, f_unf, w_unf;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mac_ifmaps_multirow_fifo #(.DATA_WIDTH(8), .NUM_ROWS(5), .DEPTH(4), .AFULL_LEVEL(3), .FWFT(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .fifo_read(fifo_read),
        .flush(flush), .out_data(a_data), .out_valid(a_valid), .fifo_full(a_full),
        .fifo_empty(a_empty), .almost_full(a_afull), .fifo_count(a_count),
        .overflow_err(a_ovf), .underflow_err(a_unf));

    mac_ifmaps_multirow_fifo #(.DATA_WIDTH(8), .NUM_ROWS(5), .DEPTH(4), .AFULL_LEVEL(3), .FWFT(1)) u_dut_f (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .fifo_read(fifo_read),
        .flush(flush), .out_data(f_data), .out_valid(f_valid), .fifo_full(f_full),
        .fifo_empty(f_empty), .almost_full(f_afull), .fifo_count(f_count),
        .overflow_err(f_ovf), .underflow_err(f_unf));

    mac_ifmaps_multirow_fifo #(.DATA_WIDTH(8), .NUM_ROWS(5), .DEPTH(2), .FWFT(0)) u_dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .fifo_read(fifo_read),
        .flush(flush), .out_data(w_data), .out_valid(w_valid), .fifo_full(w_full),
        .fifo_empty(w_empty), .almost_full(w_afull), .fifo_count(w_count),
        .overflow_err(w_ovf), .underflow_err(w_unf));

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] mkw(input logic [7:0] base);
        logic [39:0] w;
        for (int r = 0; r < 5; r++) begin
            w[r*8 +: 8] = base + 8'(r);
        end
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [39:0] d, input logic rd, input logic fl);
        in_valid  = v;
        in_data   = d;
        fifo_read = rd;
        flush     = fl;
    endtask

    logic [39:0] wa, wb, wc, wd, we, wf, wx;

    initial begin
        wa = mkw(8'h11); wb = mkw(8'h21); wc = mkw(8'h31); wd = mkw(8'h41);
        we = mkw(8'h51); wf = mkw(8'h61); wx = mkw(8'h71);

        // Reset state
        tick();
        check_eq("rst_count", 64'(a_count), 64'd0);
        check_eq("rst_empty", 64'(a_empty), 64'd1);
        check_eq("rst_full", 64'(a_full), 64'd0);
        check_eq("rst_afull", 64'(a_afull), 64'd0);
        check_eq("rst_valid", 64'(a_valid), 64'd0);
        check_eq("rst_data", 64'(a_data), 64'd0);
        check_eq("rst_errs", 64'({a_ovf, a_unf}), 64'd0);
        rst_n = 1'b1;

        // Fill A..D, watch almost_full threshold, then drain in order
        drive(1'b1, wa, 1'b0, 1'b0); tick();
        drive(1'b1, wb, 1'b0, 1'b0); tick();
        check_eq("afull_at2", 64'(a_afull), 64'd0);
        drive(1'b1, wc, 1'b0, 1'b0); tick();
        check_eq("afull_at3", 64'(a_afull), 64'd1);
        drive(1'b1, wd, 1'b0, 1'b0); tick();
        check_eq("fill_full", 64'(a_full), 64'd1);
        check_eq("fill_count", 64'(a_count), 64'd4);
        drive(1'b0, 40'h0, 1'b1, 1'b0); tick();
        check_eq("pop_a", 64'(a_data), 64'(wa));
        check_eq("pop_a_vld", 64'(a_valid), 64'd1);
        tick();
        check_eq("pop_b", 64'(a_data), 64'(wb));
        tick();
        check_eq("pop_c", 64'(a_data), 64'(wc));
        tick();
        check_eq("pop_d", 64'(a_data), 64'(wd));
        check_eq("drain_empty", 64'(a_empty), 64'd1);
        drive(1'b0, 40'h0, 1'b0, 1'b0); tick();
        check_eq("idle_vld", 64'(a_valid), 64'd0);
        check_eq("idle_hold", 64'(a_data), 64'(wd));

        // Full with simultaneous write+pop, then a dropped write
        drive(1'b1, wa, 1'b0, 1'b0); tick();
        drive(1'b1, wb, 1'b0, 1'b0); tick();
        drive(1'b1, wc, 1'b0, 1'b0); tick();
        drive(1'b1, wd, 1'b0, 1'b0); tick();
        drive(1'b1, we, 1'b1, 1'b0); tick();
        check_eq("full_rw_data", 64'(a_data), 64'(wa));
        check_eq("full_rw_count", 64'(a_count), 64'd4);
        check_eq("full_rw_ovf", 64'(a_ovf), 64'd0);
        drive(1'b1, wf, 1'b0, 1'b0); tick();
        check_eq("drop_count", 64'(a_count), 64'd4);
        check_eq("drop_ovf", 64'(a_ovf), 64'd1);
        drive(1'b0, 40'h0, 1'b0, 1'b0); tick();
        check_eq("ovf_sticky", 64'(a_ovf), 64'd1);
        drive(1'b0, 40'h0, 1'b1, 1'b0); tick();
        check_eq("after_drop_b", 64'(a_data), 64'(wb));
        drive(1'b0, 40'h0, 1'b0, 1'b1); tick();
        check_eq("flush_ovf", 64'(a_ovf), 64'd0);
        check_eq("flush_empty", 64'(a_empty), 64'd1);

        // Read+write on empty: only the write happens
        drive(1'b1, wx, 1'b1, 1'b0); tick();
        check_eq("rw_empty_count", 64'(a_count), 64'd1);
        check_eq("rw_empty_vld", 64'(a_valid), 64'd0);
        check_eq("rw_empty_unf", 64'(a_unf), 64'd1);
        drive(1'b0, 40'h0, 1'b1, 1'b0); tick();
        check_eq("rw_empty_pop", 64'(a_data), 64'(wx));
        check_eq("unf_sticky", 64'(a_unf), 64'd1);

        // Flush at count 3 overrides a same-cycle write
        drive(1'b1, wa, 1'b0, 1'b0); tick();
        drive(1'b1, wb, 1'b0, 1'b0); tick();
        drive(1'b1, wc, 1'b0, 1'b0); tick();
        check_eq("pre_flush_count", 64'(a_count), 64'd3);
        drive(1'b1, wd, 1'b1, 1'b1); tick();
        check_eq("flush3_count", 64'(a_count), 64'd0);
        check_eq("flush3_empty", 64'(a_empty), 64'd1);
        check_eq("flush3_errs", 64'({a_ovf, a_unf}), 64'd0);
        check_eq("flush3_vld", 64'(a_valid), 64'd0);
        check_eq("flush3_hold", 64'(a_data), 64'(wx));

        // Fall-through head visibility
        drive(1'b0, 40'h0, 1'b0, 1'b0); tick();
        check_eq("fwft_empty_vld", 64'(f_valid), 64'd0);
        drive(1'b1, wa, 1'b0, 1'b0); tick();
        check_eq("fwft_w0_vld", 64'(f_valid), 64'd1);
        check_eq("fwft_w0_data", 64'(f_data), 64'(wa));
        drive(1'b1, wb, 1'b1, 1'b0); tick();
        check_eq("fwft_w1_data", 64'(f_data), 64'(wb));
        check_eq("fwft_w1_count", 64'(f_count), 64'd1);
        drive(1'b0, 40'h0, 1'b1, 1'b0); tick();
        check_eq("fwft_drain_vld", 64'(f_valid), 64'd0);

        // DEPTH=2 wrap with simultaneous write+pop
        drive(1'b0, 40'h0, 1'b0, 1'b1); tick();
        drive(1'b1, mkw(8'h80), 1'b0, 1'b0); tick();
        for (int k = 1; k < 10; k++) begin
            drive(1'b1, mkw(8'h80 + 8'(k * 8)), 1'b1, 1'b0); tick();
            check_eq($sformatf("wrap_data%0d", k), 64'(w_data), 64'(mkw(8'h80 + 8'((k - 1) * 8))));
            check_eq($sformatf("wrap_count%0d", k), 64'(w_count), 64'd1);
        end
        drive(1'b0, 40'h0, 1'b1, 1'b0); tick();
        check_eq("wrap_last", 64'(w_data), 64'(mkw(8'hC8)));
        check_eq("wrap_empty", 64'(w_empty), 64'd1);

        // Asynchronous reset between edges
        drive(1'b1, wc, 1'b0, 1'b0); tick();
        drive(1'b1, wd, 1'b1, 1'b0); tick();
        check_eq("pre_rst_data", 64'(a_data), 64'(wc));
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_count", 64'(a_count), 64'd0);
        check_eq("arst_data", 64'(a_data), 64'd0);
        check_eq("arst_vld", 64'(a_valid), 64'd0);
        check_eq("arst_empty", 64'(a_empty), 64'd1);
        check_eq("arst_fdata", 64'(f_data), 64'd0);
        check_eq("arst_fvld", 64'(f_valid), 64'd0);
        drive(1'b0, 40'h0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_empty", 64'(a_empty), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
